// File: rtl/xfcp_drp_arb.sv
// Round-robin arbiter sharing one transceiver DRP port between PORTS requesters.
// Define XFCP_DRP_ARB_TIMEOUT_EN to enable the rdy timeout / abort path.
module xfcp_drp_arb #(
    parameter int unsigned PORTS      = 2,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*ADDR_WIDTH-1:0] s_drp_addr,
    input  logic [PORTS*16-1:0]         s_drp_do,
    output logic [PORTS*16-1:0]         s_drp_di,
    input  logic [PORTS-1:0]            s_drp_en,
    input  logic [PORTS-1:0]            s_drp_we,
    output logic [PORTS-1:0]            s_drp_rdy,
    output logic [ADDR_WIDTH-1:0]       m_drp_addr,
    output logic [15:0]                 m_drp_do,
    input  logic [15:0]                 m_drp_di,
    output logic                        m_drp_en,
    output logic                        m_drp_we,
    input  logic                        m_drp_rdy,
    output logic                        busy,
    output logic                        timeout
);

    localparam int unsigned IdxW = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [PORTS-1:0]      pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] addr_q [PORTS];
    logic [15:0]           wdata_q [PORTS];
    logic [PORTS-1:0]      we_q;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [IdxW-1:0]       grant_q, grant_d;
    logic                  grant_vld;
    logic [ADDR_WIDTH-1:0] m_addr_q;
    logic [15:0]           m_do_q;
    logic                  m_we_q;
    logic [PORTS*16-1:0]   di_q, di_d;
    logic                  timeout_q, timeout_d;
    logic                  expire;

    // A strobe is only captured into an empty slot; repeats while pending are dropped.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (s_drp_en[i] && !pend_q[i]) begin
                pend_d[i] = 1'b1;
            end
        end
        if (state_q == StResp) begin
            pend_d[grant_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (s_drp_en[i] && !pend_q[i]) begin
                addr_q[i]  <= s_drp_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q[i] <= s_drp_do[i*16 +: 16];
                we_q[i]    <= s_drp_we[i];
            end
        end
    end

    // First pending port at or after the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_d   = grant_q;
        for (int unsigned k = 0; k < PORTS; k++) begin
            idx = (int'(ptr_q) + k) % PORTS;
            if (!grant_vld && pend_q[idx]) begin
                grant_vld = 1'b1;
                grant_d   = IdxW'(idx);
            end
        end
    end

`ifdef XFCP_DRP_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;

    assign expire = (state_q == StWait) && (cnt_q == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == StIssue) begin
            cnt_q <= '0;
        end else if (state_q == StWait && !m_drp_rdy && !expire) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`else
    logic [15:0] unused_timeout_param;

    assign unused_timeout_param = 16'(TIMEOUT);
    assign expire               = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        di_d      = di_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    state_d = StIssue;
                    ptr_d   = IdxW'((int'(grant_d) + 1) % PORTS);
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                // A real rdy in the expiry cycle takes priority over the abort.
                if (m_drp_rdy) begin
                    state_d                       = StResp;
                    di_d[int'(grant_q)*16 +: 16] = m_drp_di;
                end else if (expire) begin
                    state_d                       = StResp;
                    di_d[int'(grant_q)*16 +: 16] = 16'hFFFF;
                    timeout_d                     = 1'b1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            pend_q    <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            m_addr_q  <= '0;
            m_do_q    <= '0;
            m_we_q    <= 1'b0;
            di_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            di_q      <= di_d;
            timeout_q <= timeout_d;
            if (state_q == StIdle && grant_vld) begin
                grant_q  <= grant_d;
                m_addr_q <= addr_q[grant_d];
                m_do_q   <= wdata_q[grant_d];
                m_we_q   <= we_q[grant_d];
            end
        end
    end

    assign m_drp_en   = (state_q == StIssue);
    assign m_drp_we   = m_drp_en & m_we_q;
    assign m_drp_addr = m_addr_q;
    assign m_drp_do   = m_do_q;
    assign busy       = (state_q != StIdle);
    assign timeout    = timeout_q;
    assign s_drp_di   = di_q;
    assign s_drp_rdy  = (state_q == StResp) ? (PORTS'(1) << grant_q) : '0;

endmodule
